// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
// Flags are always packed as {C,Z,N,V} through make_flags so bit order lives in one place.
package alu_pkg;

    localparam int OP_ADD   = 0;
    localparam int OP_LOAD  = 1;
    localparam int OP_STORE = 2;
    localparam int OP_CALL  = 3;
    localparam int OP_RET   = 4;
    localparam int OP_SUB   = 5;
    localparam int OP_AND   = 6;
    localparam int OP_OR    = 7;
    localparam int OP_XOR   = 8;
    localparam int OP_SHL   = 9;
    localparam int OP_SHR   = 10;
    localparam int OP_MUL   = 11;

    localparam int F_C = 3;
    localparam int F_Z = 2;
    localparam int F_N = 1;
    localparam int F_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic [3:0] make_flags(input logic c, input logic z,
                                              input logic n, input logic v);
        logic [3:0] f;
        f      = '0;
        f[F_C] = c;
        f[F_Z] = z;
        f[F_N] = n;
        f[F_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between decode/register-read and writeback.
// The master issues ops and consumes results; the ALU is the slave.
interface alu_seq_if #(
    parameter int WIDTH = 18,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] ina;
    logic [WIDTH-1:0] inb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, ina, inb, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, op, ina, inb, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per enabled cycle, WIDTH cycles per product.
// done is high during the last iteration; product then already holds the final 2*WIDTH-bit result.
module alu_mul_seq #(
    parameter int WIDTH = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic [2*WIDTH-1:0] addend;

    // Partial product for the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
            assign addend[gi] = a_reg[gi] & b_reg[0];
        end
    endgenerate

    assign product = acc_reg + addend;
    assign done    = busy_reg & (cnt_reg == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (en) begin
            if (start) begin
                a_reg    <= {{WIDTH{1'b0}}, a};
                b_reg    <= b;
                acc_reg  <= '0;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                acc_reg <= product;
                a_reg   <= a_reg << 1;
                b_reg   <= b_reg >> 1;
                cnt_reg <= cnt_reg + 1'b1;
                if (done) begin
                    busy_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and {C,Z,N,V} flags; single-cycle ops
// complete on the edge after accept, MUL runs through alu_mul_seq for WIDTH more cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int OPW   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   out_reg, out_next;
    logic [3:0]         flags_reg, flags_next;
    logic               out_valid_reg, out_valid_next;

    logic               accept, drain, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   alu_out;
    logic [3:0]         alu_flags;
    logic               c_bit, v_bit;
    logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
    logic [SHW-1:0]     shamt;

    assign bus.in_ready  = en & (state_reg == IDLE) & (~out_valid_reg | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign drain         = en & out_valid_reg & bus.out_ready;
    assign bus.out       = out_reg;
    assign bus.flags     = flags_reg;
    assign bus.out_valid = out_valid_reg;

    // One guard bit above the operand captures carry/borrow and the last shifted-out bit.
    assign shamt   = bus.inb[SHW-1:0];
    assign sum     = {1'b0, bus.ina} + {1'b0, bus.inb};
    assign diff    = {1'b0, bus.ina} - {1'b0, bus.inb};
    assign shl_ext = {1'b0, bus.ina} << shamt;
    assign shr_ext = {bus.ina, 1'b0} >> shamt;

    always_comb begin
        alu_out = '0;
        c_bit   = 1'b0;
        v_bit   = 1'b0;
        case (int'(bus.op))
            OP_ADD: begin
                alu_out = sum[MSB:0];
                c_bit   = sum[WIDTH];
                v_bit   = (bus.ina[MSB] == bus.inb[MSB]) & (sum[MSB] != bus.ina[MSB]);
            end
            OP_LOAD, OP_STORE: alu_out = bus.ina;
            OP_CALL, OP_RET:   alu_out = bus.inb;
            OP_SUB: begin
                alu_out = diff[MSB:0];
                c_bit   = diff[WIDTH];
                v_bit   = (bus.ina[MSB] != bus.inb[MSB]) & (diff[MSB] != bus.ina[MSB]);
            end
            OP_AND: alu_out = bus.ina & bus.inb;
            OP_OR:  alu_out = bus.ina | bus.inb;
            OP_XOR: alu_out = bus.ina ^ bus.inb;
            OP_SHL: begin
                alu_out = shl_ext[MSB:0];
                c_bit   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_out = shr_ext[WIDTH:1];
                c_bit   = shr_ext[0];
            end
            default: alu_out = '0;
        endcase
        alu_flags = make_flags(c_bit, alu_out == '0, alu_out[MSB], v_bit);
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (mul_start),
        .a       (bus.ina),
        .b       (bus.inb),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_next     = state_reg;
        out_next       = out_reg;
        flags_next     = flags_reg;
        out_valid_next = out_valid_reg;
        mul_start      = 1'b0;
        if (en) begin
            if (drain) begin
                out_valid_next = 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (int'(bus.op) == OP_MUL) begin
                            mul_start  = 1'b1;
                            state_next = MUL;
                        end else begin
                            out_next       = alu_out;
                            flags_next     = alu_flags;
                            out_valid_next = 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        out_next       = mul_product[MSB:0];
                        flags_next     = make_flags(|mul_product[2*WIDTH-1:WIDTH],
                                                    mul_product[MSB:0] == '0,
                                                    mul_product[MSB], 1'b0);
                        out_valid_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_reg       <= out_next;
            flags_reg     <= flags_next;
            out_valid_reg <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq against an arithmetic reference model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_seq;
    localparam int W   = 18;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_if #(.WIDTH(W), .OPW(OPW)) bif ();

    alu_seq #(.WIDTH(W), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the opcode rules.
    function automatic void model(input int o, input longint a, input longint b,
                                  output longint r, output logic [3:0] f);
        longint m, sa, sb, t, sv;
        int     sh;
        logic   c, v;
        m  = longint'(1) << W;
        sa = (a >= m/2) ? a - m : a;
        sb = (b >= m/2) ? b - m : b;
        sh = int'(b % (longint'(1) << $clog2(W)));
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (o)
            0: begin
                t = a + b; r = t % m; c = (t >= m);
                sv = sa + sb; v = (sv > m/2 - 1) || (sv < -(m/2));
            end
            1, 2: r = a;
            3, 4: r = b;
            5: begin
                r = (a - b + m) % m; c = (a < b);
                sv = sa - sb; v = (sv > m/2 - 1) || (sv < -(m/2));
            end
            6: r = a & b;
            7: r = a | b;
            8: r = a ^ b;
            9: begin
                r = (sh >= W) ? 0 : (a << sh) % m;
                c = (sh >= 1 && sh <= W) ? ((a >> (W - sh)) & 1) != 0 : 1'b0;
            end
            10: begin
                r = (sh >= W) ? 0 : (a >> sh);
                c = (sh >= 1 && sh <= W) ? ((a >> (sh - 1)) & 1) != 0 : 1'b0;
            end
            11: begin
                t = a * b; r = t % m; c = (t / m) != 0;
            end
            default: r = 0;
        endcase
        f = {c, r == 0, r >= m/2, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bif.in_ready && n < 100) begin
            step();
            n++;
        end
        check_eq({tag, "_in_ready"}, 64'(bif.in_ready), 64'd1);
    endtask

    // Issue one op, wait for its result, check latency, value and flags; result drains next edge.
    task automatic run_op(input int o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        longint     er;
        logic [3:0] ef;
        int         lat, exp_lat;
        logic       saw_rdy;
        model(o, longint'(a), longint'(b), er, ef);
        exp_lat = (o == 11) ? W + 1 : 1;
        bif.out_ready = 1'b1;
        wait_ready(tag);
        bif.in_valid = 1'b1;
        bif.op  = OPW'(o);
        bif.ina = a;
        bif.inb = b;
        step();
        bif.in_valid = 1'b0;
        bif.op  = OPW'($urandom_range(0, 15));
        bif.ina = W'($urandom);
        bif.inb = W'($urandom);
        lat = 1;
        saw_rdy = 1'b0;
        while (!bif.out_valid && lat < 100) begin
            if (bif.in_ready) saw_rdy = 1'b1;
            step();
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_out"}, 64'(bif.out), 64'(er));
        check_eq({tag, "_flags"}, 64'(bif.flags), 64'(ef));
        if (o == 11) check_eq({tag, "_mul_in_ready"}, 64'(saw_rdy), 64'd0);
        $display("op=%0d a=%05h b=%05h -> out=%05h flags=%04b lat=%0d", o, a, b, bif.out, bif.flags, lat);
    endtask

    initial begin
        logic [W-1:0] hold_out;
        logic [3:0]   hold_flags;
        longint       er;
        logic [3:0]   ef;
        logic [W-1:0] q_exp[$];
        int           lat, nvalid;

        rst_n = 1'b0;
        en    = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        bif.op  = '0;
        bif.ina = '0;
        bif.inb = '0;
        repeat (3) step();
        check_eq("rst_out", 64'(bif.out), 64'd0);
        check_eq("rst_flags", 64'(bif.flags), 64'd0);
        check_eq("rst_out_valid", 64'(bif.out_valid), 64'd0);
        rst_n = 1'b1;
        step();
        check_eq("rst_in_ready", 64'(bif.in_ready), 64'd1);
        en = 1'b0;
        #1;
        check_eq("en_low_in_ready", 64'(bif.in_ready), 64'd0);
        en = 1'b1;
        step();

        // Directed corner cases.
        run_op(0, 18'h3FFFF, 18'h00001, "add_wrap");
        check_eq("add_wrap_lit", {bif.flags, 14'd0, bif.out}, {4'b1100, 14'd0, 18'h00000});
        run_op(5, 18'h00005, 18'h00007, "sub_borrow");
        check_eq("sub_borrow_lit", {bif.flags, 14'd0, bif.out}, {4'b1010, 14'd0, 18'h3FFFE});
        run_op(0, 18'h1FFFF, 18'h00001, "add_ovf");
        check_eq("add_ovf_lit", {bif.flags, 14'd0, bif.out}, {4'b0011, 14'd0, 18'h20000});
        run_op(11, 18'h00123, 18'h00045, "mul_dir");
        check_eq("mul_dir_lit", {bif.flags, 14'd0, bif.out}, {4'b0000, 14'd0, 18'h04E6F});
        run_op(13, 18'h12345, 18'h00777, "undef");
        run_op(9, 18'h00001, 18'd17, "shl17");
        run_op(10, 18'h3FFFF, 18'd18, "shr18");
        step();

        // Output hold with consumer stalled, then drain and accept in the same cycle.
        bif.out_ready = 1'b0;
        wait_ready("hold");
        bif.in_valid = 1'b1; bif.op = OPW'(0); bif.ina = 18'h01234; bif.inb = 18'h00F00;
        step();
        bif.in_valid = 1'b0;
        model(0, 64'h01234, 64'h00F00, er, ef);
        check_eq("hold_first", 64'(bif.out), 64'(er));
        hold_out   = bif.out;
        hold_flags = bif.flags;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_out", {bif.out_valid, bif.in_ready, bif.flags, bif.out},
                     {1'b1, 1'b0, hold_flags, hold_out});
        end
        bif.in_valid = 1'b1; bif.op = OPW'(0); bif.ina = 18'h2AAAA; bif.inb = 18'h15555;
        bif.out_ready = 1'b1;
        #1;
        check_eq("drain_accept_rdy", 64'(bif.in_ready), 64'd1);
        step();
        bif.in_valid = 1'b0;
        model(0, 64'h2AAAA, 64'h15555, er, ef);
        check_eq("drain_accept_out", {bif.out_valid, bif.flags, bif.out}, {1'b1, ef, W'(er)});
        step();

        // Back-to-back LOAD/CALL stream.
        for (int i = 0; i < 4; i++) begin
            bif.in_valid = 1'b1;
            bif.op  = OPW'((i % 2 == 0) ? 1 : 3);
            bif.ina = W'($urandom);
            bif.inb = W'($urandom);
            q_exp.push_back((i % 2 == 0) ? bif.ina : bif.inb);
            check_eq("b2b_rdy", 64'(bif.in_ready), 64'd1);
            step();
            check_eq("b2b_out", {bif.out_valid, bif.out}, {1'b1, q_exp.pop_front()});
        end
        bif.in_valid = 1'b0;
        step();

        // Reset in the middle of a multiply.
        wait_ready("rstmul");
        bif.in_valid = 1'b1; bif.op = OPW'(11); bif.ina = 18'h0ABCD; bif.inb = 18'h00321;
        step();
        bif.in_valid = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check_eq("rstmul_out", {bif.out_valid, bif.out}, {1'b0, W'(0)});
        step();
        rst_n = 1'b1;
        step();
        check_eq("rstmul_in_ready", 64'(bif.in_ready), 64'd1);
        nvalid = 0;
        for (int i = 0; i < 25; i++) begin
            if (bif.out_valid) nvalid++;
            step();
        end
        check_eq("rstmul_no_result", 64'(nvalid), 64'd0);

        // Clock-enable pause during a multiply.
        wait_ready("enmul");
        bif.in_valid = 1'b1; bif.op = OPW'(11); bif.ina = 18'h01F3D; bif.inb = 18'h0077B;
        step();
        bif.in_valid = 1'b0;
        lat = 1;
        while (!bif.out_valid && lat < 100) begin
            en = (lat >= 5 && lat < 8) ? 1'b0 : 1'b1;
            step();
            lat++;
        end
        en = 1'b1;
        model(11, 64'h01F3D, 64'h0077B, er, ef);
        check_eq("enmul_lat", 64'(lat), 64'(W + 4));
        check_eq("enmul_out", {bif.flags, bif.out}, {ef, W'(er)});
        step();

        // Random ops.
        for (int i = 0; i < 150; i++) begin
            int           o;
            logic [W-1:0] a, b;
            o = $urandom_range(0, 15);
            a = W'($urandom);
            b = W'($urandom);
            if ((o == 9 || o == 10) && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = W'($urandom_range(0, 3)) << (W - 2);
            run_op(o, a, b, "rnd");
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
